pow_iter: RTL
=============

# pow_iter

Parametrised successor to the `pow2` datapath block. It computes `base_i ** exp_i` modulo 2^`width_p` by iterative square-and-multiply, one exponent bit per cycle, and reports overflow. It keeps the same ready/valid input and valid/yumi output handshakes, so it drops into the existing trace-replay benches in place of `pow2`. `pow2` is the special case `base_i = 2`.

## Interface
- `width_p`, 32: width of base, result and intermediate operands.
- `exp_width_p`, 32: width of the exponent input.
- `saturate_p`, 0: when 1, `data_o` is all ones whenever `ovf_o` is 1; when 0, `data_o` is the true result modulo 2^`width_p`.

Ports:
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `base_i`  in  `width_p`  base operand; sampled on acceptance.
- `exp_i`  in  `exp_width_p`  exponent; sampled on acceptance.
- `v_i`  in  1  input valid.
- `ready_o`  out  1  block can accept; a transfer occurs when `v_i & ready_o` at a rising edge.
- `data_o`  out  `width_p`  result; held stable while `v_o` is 1.
- `ovf_o`  out  1  true result ≥ 2^`width_p`; valid with `v_o`.
- `v_o`  out  1  result valid.
- `yumi_i`  in  1  consumer takes the result. Legal only while `v_o` is 1; behaviour is undefined otherwise.

## Operation
- State machine: IDLE, BUSY, DONE. Registers: `acc` (`width_p`), `b` (`width_p`), `e` (`exp_width_p`), `acc_ovf`, `b_ovf`.
- IDLE:
  - `ready_o` = 1.
  - On `v_i`: `acc` ← 1, `b` ← `base_i`, `e` ← `exp_i`, both overflow flags ← 0, go to BUSY.
- BUSY, every cycle:
  - Compute the full 2·`width_p`-bit products `acc·b` and `b·b`.
  - If `e[0]`:
    - `acc` ← low half of `acc·b`.
    - `acc_ovf` ← `acc_ovf | b_ovf | (high half of acc·b ≠ 0)`.
  - `e` ← `e >> 1`.
  - If the shifted `e` ≠ 0:
    - `b` ← low half of `b·b`.
    - `b_ovf` ← `b_ovf | (high half of b·b ≠ 0)`.
  - If the shifted `e` = 0, `b` and `b_ovf` are left unchanged, so a squaring that is never used cannot flag overflow.
  - Go to DONE when the shifted `e` = 0.
- DONE:
  - `v_o` = 1, `ovf_o` = `acc_ovf`.
  - `data_o` = all ones if `saturate_p & acc_ovf`, else `acc`.
  - On `yumi_i`, go to IDLE.
- `exp_i` = 0 gives `data_o` = 1 and `ovf_o` = 0 for any base, including 0.
- Base 0 or 1 never overflows.
- Multiplier: two combinational `width_p`×`width_p` unsigned multipliers, each completing in a single cycle. No multicycle paths.

## Timing
- Reset (`reset_n_i` low, asynchronous):
  - State = IDLE, `ready_o` = 0, `v_o` = 0, `ovf_o` = 0, `data_o` = 0, all datapath registers = 0.
  - `ready_o` rises at the first rising edge after `reset_n_i` deasserts.
- Reset asserted mid-BUSY or mid-DONE aborts the operation immediately. No result is produced.
- Latency: acceptance at edge k gives `v_o` high after edge k+n, where n = max(1, index of MSB of `exp_i` + 1). Examples: n = 1 for `exp_i` = 0 or 1; n = 32 for `exp_i` ≥ 2^31.
- `ready_o` is 0 from the accept edge until `yumi_i` is taken. It is 1 in the cycle after the `yumi_i` edge, so at most one operation is in flight.
- Back-to-back minimum spacing is n+2 cycles per operation.
- `data_o` and `ovf_o` stay constant for as long as `v_o` is held and `yumi_i` is 0.
- `ready_o`, `v_o`, `data_o` and `ovf_o` are functions of registered state only. There is no combinational path from `v_i` or `yumi_i` to any output.

## Test plan
- Base 2, exp 10 → `data_o` = 1024, `ovf_o` = 0, `v_o` 4 cycles after accept. Repeat with base 3, exp 0 → `data_o` = 1, latency 1.
- Base 2, exp 31 → `data_o` = 0x8000_0000, `ovf_o` = 0. Base 2, exp 32 → `ovf_o` = 1 and `data_o` = 0 (`saturate_p` = 0), or `data_o` = 0xFFFF_FFFF (`saturate_p` = 1).
- Base 0x0001_0000, exp 1 → `data_o` = 0x0001_0000, `ovf_o` = 0 (the unused squaring must not flag). Base 0x0001_0000, exp 2 → `ovf_o` = 1.
- Backpressure: base 7, exp 3, `yumi_i` held low 5 cycles after `v_o` → `data_o` = 343 stable throughout and `ready_o` = 0. After the `yumi_i` edge, `ready_o` = 1 in the next cycle.
- Reset mid-BUSY: base 2, exp 0xFFFF_FFFF, `reset_n_i` pulsed low at cycle 10 → `v_o` = 0 and `ready_o` = 0 immediately, `ready_o` = 1 one edge after release. A following base 5, exp 2 → 25.
- Random sweep of 1000 operations (width_p = 16 and 32) with random `v_i` and `yumi_i` gaps, checked against a reference model for `data_o`, `ovf_o` and latency.

Source files
------------

// File: rtl/pow_iter_if.sv
// Handshake bundle for pow_iter: ready/valid operand input, valid/yumi result output.
// The producer/consumer side takes the master modport; the block itself takes slave.
interface pow_iter_if #(
   parameter int width_p     = 32,
   parameter int exp_width_p = 32
);
   logic [width_p-1:0]     base_i;
   logic [exp_width_p-1:0] exp_i;
   logic                   v_i;
   logic                   ready_o;
   logic [width_p-1:0]     data_o;
   logic                   ovf_o;
   logic                   v_o;
   logic                   yumi_i;

   modport master (
      output base_i, exp_i, v_i, yumi_i,
      input  ready_o, data_o, ovf_o, v_o
   );

   modport slave (
      input  base_i, exp_i, v_i, yumi_i,
      output ready_o, data_o, ovf_o, v_o
   );
endinterface

// File: rtl/pow_iter.sv
// Iterative base**exp modulo 2^width_p, one exponent bit per cycle (right-to-left
// square-and-multiply), with overflow tracking and optional saturation.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for operands (ready once the post-reset edge has passed)
// S_BUSY | consuming one exponent bit per cycle
// S_DONE | result presented, held until yumi
module pow_iter #(
   parameter int width_p     = 32,
   parameter int exp_width_p = 32,
   parameter bit saturate_p  = 1'b0
) (
   input  logic       clk_i,
   input  logic       reset_n_i,
   pow_iter_if.slave  io
);
   localparam int prod_w_lp = 2 * width_p;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   init_q;
   logic [width_p-1:0]     acc_q, acc_d;
   logic [width_p-1:0]     b_q, b_d;
   logic [exp_width_p-1:0] e_q, e_d;
   logic                   acc_ovf_q, acc_ovf_d;
   logic                   b_ovf_q, b_ovf_d;

   logic [prod_w_lp-1:0]   ab_full, bb_full;
   logic [exp_width_p-1:0] e_shift;
   logic                   last_bit;
   logic                   accept;

   assign ab_full  = prod_w_lp'(acc_q) * prod_w_lp'(b_q);
   assign bb_full  = prod_w_lp'(b_q) * prod_w_lp'(b_q);
   assign e_shift  = e_q >> 1;
   assign last_bit = (e_shift == '0);
   assign accept   = (state_q == S_IDLE) && init_q && io.v_i;

   // init_q holds ready low until the first edge after reset release
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         init_q  <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept)    state_d = S_BUSY;
         S_BUSY:  if (last_bit)  state_d = S_DONE;
         S_DONE:  if (io.yumi_i) state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   always_comb begin
      acc_d     = acc_q;
      b_d       = b_q;
      e_d       = e_q;
      acc_ovf_d = acc_ovf_q;
      b_ovf_d   = b_ovf_q;
      if (accept) begin
         acc_d     = width_p'(1);
         b_d       = io.base_i;
         e_d       = io.exp_i;
         acc_ovf_d = 1'b0;
         b_ovf_d   = 1'b0;
      end else if (state_q == S_BUSY) begin
         if (e_q[0]) begin
            acc_d     = ab_full[width_p-1:0];
            acc_ovf_d = acc_ovf_q | b_ovf_q | (|ab_full[prod_w_lp-1:width_p]);
         end
         e_d = e_shift;
         // skip the final squaring so an unused square cannot raise overflow
         if (!last_bit) begin
            b_d     = bb_full[width_p-1:0];
            b_ovf_d = b_ovf_q | (|bb_full[prod_w_lp-1:width_p]);
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         acc_q     <= '0;
         b_q       <= '0;
         e_q       <= '0;
         acc_ovf_q <= 1'b0;
         b_ovf_q   <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         b_q       <= b_d;
         e_q       <= e_d;
         acc_ovf_q <= acc_ovf_d;
         b_ovf_q   <= b_ovf_d;
      end
   end

   always_comb begin
      io.ready_o = (state_q == S_IDLE) && init_q;
      io.v_o     = (state_q == S_DONE);
      io.ovf_o   = acc_ovf_q;
      io.data_o  = (saturate_p && acc_ovf_q) ? '1 : acc_q;
   end
endmodule
